mmu_sequencer: RTL and testbench
================================

// Module: mmu_sequencer
// PURPOSE
// - Sequences one 2x2 weight-stationary matrix-multiply job on the mmu systolic array.
// - Per job:
//   - latch four 8-bit weights and pulse load_weight;
//   - stream N input rows from an external input buffer, with column skew applied;
//   - hold valid while partial sums ripple down the array;
//   - realign both column results and write one packed result word per row.
// - Sits between the top-level command interface and the mmu instance, and drives all mmu inputs.
// PARAMETERS
// - ADDR_W    4  address width of input and result buffers; max rows = 2**ADDR_W
// - COL0_LAT  2  cycles from a_in1 of row k to acc_out1 of row k (fixed by the array)
// - COL1_LAT  3  cycles from a_in1 of row k to acc_out2 of row k (fixed by the array)
// PORTS
// - clk           in   1       rising-edge clock
// - reset         in   1       synchronous, active-high reset
// - start         in   1       job request; sampled only in IDLE
// - num_rows      in   ADDR_W+1  rows N in job; 0..2**ADDR_W; sampled with start
// - w_data        in   32      {w4,w3,w2,w1}; sampled with start
// - busy          out  1       high from the cycle after an accepted start until done
// - done          out  1       1-cycle pulse when the job completes
// - rd_en         out  1       input buffer read strobe; read data returns 1 cycle later
// - rd_addr       out  ADDR_W  input row address, 0..N-1
// - rd_data       in   16      {A[k][1], A[k][0]}
// - load_weight   out  1       to mmu
// - valid         out  1       to mmu
// - a_in1, a_in2  out  8 each  to mmu
// - weight1..4    out  8 each  to mmu
// - acc_out1/2    in   8 each  from mmu
// - wr_en         out  1       result write strobe
// - wr_addr       out  ADDR_W  result row k
// - wr_data       out  16      {C[k][1], C[k][0]}
// BEHAVIOUR
// - Reset: FSM to IDLE; every output and internal register to 0.
//   - Reset mid-job abandons the job: no done pulse, no further writes.
// - FSM states: IDLE -> LOADW -> FEED -> DRAIN -> DONE -> IDLE.
//   - IDLE:
//     - start=1 and N>0: latch w_data into weight1..4 (held until next start) and N; go to LOADW.
//     - start=1 and N=0: go straight to DONE; no reads, no writes, no load_weight.
//     - start while not in IDLE is ignored.
//   - LOADW: load_weight=1 for exactly 1 cycle, valid=0; the first read (rd_en=1, rd_addr=0) issues in the same cycle; go to FEED.
//   - FEED: one read per cycle, addresses 1..N-1; leave FEED after the cycle that issues address N-1.
//   - DRAIN: until last write issued, then DONE.
//   - DONE: done=1 and busy=0 for exactly 1 cycle; go to IDLE.
// - Feed cycle f=0 is the cycle after the address-0 read:
//   - a_in1 = A[f][0] for f in 0..N-1; 0 otherwise.
//   - a_in2 = A[f-1][1] for f in 1..N; 0 otherwise (1-cycle skew register).
//   - valid=1 from f=0 through the final capture cycle f=N-1+COL1_LAT; 0 otherwise.
// - Capture:
//   - At f=k+COL0_LAT, store acc_out1 as C[k][0] in a 1-deep holding register.
//   - At f=k+COL1_LAT: wr_en=1, wr_addr=k, wr_data={acc_out2, held C[k][0]}.
//   - Exactly N writes, in ascending k; one per cycle, consecutive.
// - Arithmetic: none in this block; results are the 8-bit array outputs, truncated modulo 256.
// - Latency: start accepted at cycle 0 -> done at cycle N+COL1_LAT+3 (N>0), or cycle 1 (N=0).
// - N=2**ADDR_W: the address counter must not wrap before its last read; addresses 0..2**ADDR_W-1 each read once.
// CONFIGURATION
// - MMU_SEQ_PERF_EN defined:
//   - Adds output perf_cycles [15:0].
//   - Clears on accepted start; increments every busy cycle; saturates at 16'hFFFF.
//   - Holds after done until the next start; 0 on reset.
// - MMU_SEQ_PERF_EN undefined: no port, no counter logic; all other behaviour identical.
// TESTING
// - Weights {4,3,2,1}, A rows [1,2],[3,4], N=2 -> wr_data[0]=16'h0B05, wr_data[1]=16'h190B; done at cycle 8.
// - N=0 start -> done pulse at cycle 1; no rd_en, wr_en or load_weight ever asserted.
// - N=16, all weights 1, A[k]=[k,k] -> 16 writes, addresses 0..15, wr_data[k]={2k,2k}; rd_addr never wraps.
// - Overflow: weights all 16, A row [16,16] -> wr_data=16'h0000 (512 mod 256).
// - start pulsed during FEED, and reset asserted mid-DRAIN:
//   - the start has no effect;
//   - after reset: all outputs 0, no done pulse;
//   - a new N=1 job then completes correctly.
// - With MMU_SEQ_PERF_EN: N=2 job -> perf_cycles=7 after done, held until the next start.

Source files
------------

// File: rtl/mmu_sequencer.sv
// Purpose : sequences one 2x2 weight-stationary matmul job (weight load, skewed row feed, drain, result write).
// Latency : start accepted at cycle 0 -> done at cycle N+COL1_LAT+3 (N>0), cycle 1 (N=0); one result per cycle.
// Backpressure: none; input/result buffers always accept, start is ignored outside IDLE.
// Optional feature: define MMU_SEQ_PERF_EN to add the perf_cycles busy-cycle counter output.
module mmu_sequencer #(
    parameter int ADDR_W   = 4,
    parameter int COL0_LAT = 2,
    parameter int COL1_LAT = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W:0]   num_rows,
    input  logic [31:0]       w_data,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [15:0]       rd_data,
    output logic              load_weight,
    output logic              valid,
    output logic [7:0]        a_in1,
    output logic [7:0]        a_in2,
    output logic [7:0]        weight1,
    output logic [7:0]        weight2,
    output logic [7:0]        weight3,
    output logic [7:0]        weight4,
    input  logic [7:0]        acc_out1,
    input  logic [7:0]        acc_out2,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [15:0]       wr_data
`ifdef MMU_SEQ_PERF_EN
    ,
    output logic [15:0]       perf_cycles
`endif
);

    // Feed counter is wide enough to reach N + COL1_LAT for N = 2**ADDR_W.
    localparam int FW = ADDR_W + 3;

    localparam logic [FW-1:0]   L0    = FW'(COL0_LAT);
    localparam logic [FW-1:0]   L1    = FW'(COL1_LAT);
    localparam logic [FW-1:0]   ONE_F = FW'(1);
    localparam logic [ADDR_W:0] ONE_N = (ADDR_W + 1)'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOADW = 3'd1,
        S_FEED  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t            state;
    logic [ADDR_W:0]   n_q;        // rows in the current job
    logic              run;        // high from feed cycle f=0 until the job finishes
    logic [FW-1:0]     f;          // feed cycle index, valid while run
    logic [7:0]        skew_q;     // column-1 operand delayed one cycle
    logic [7:0]        hold_q;     // column-0 result waiting for its column-1 partner
    logic [ADDR_W-1:0] wcnt;       // next result row to write

    logic [FW-1:0]     n_f;
    logic              accept;
    logic              feed_row;
    logic              cap0;
    logic              cap1;
    logic              last_cap;
    logic              finish;

    // Decode the feed/capture windows from the feed counter.
    always_comb begin
        n_f      = FW'(n_q);
        accept   = (state == S_IDLE) && start;
        feed_row = run && (f < n_f);
        cap0     = run && (f >= L0) && (f < n_f + L0);
        cap1     = run && (f >= L1) && (f < n_f + L1);
        last_cap = run && (f == n_f + L1 - ONE_F);
        finish   = (state == S_DRAIN) && (f == n_f + L1);
    end

    // Column-0 operand comes straight from the buffer read data during its feed cycle.
    assign a_in1 = feed_row ? rd_data[7:0] : 8'h00;
    assign a_in2 = skew_q;

    // Job control FSM: weight latch, read address generation, busy/done handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            n_q         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            rd_en       <= 1'b0;
            rd_addr     <= '0;
            load_weight <= 1'b0;
            weight1     <= 8'h00;
            weight2     <= 8'h00;
            weight3     <= 8'h00;
            weight4     <= 8'h00;
        end else begin
            load_weight <= 1'b0;
            done        <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (num_rows != '0) begin
                            weight1     <= w_data[7:0];
                            weight2     <= w_data[15:8];
                            weight3     <= w_data[23:16];
                            weight4     <= w_data[31:24];
                            n_q         <= num_rows;
                            busy        <= 1'b1;
                            load_weight <= 1'b1;
                            rd_en       <= 1'b1;
                            rd_addr     <= '0;
                            state       <= S_LOADW;
                        end else begin
                            // Empty job: no weights, reads or writes, just the completion pulse.
                            done  <= 1'b1;
                            state <= S_DONE;
                        end
                    end
                end
                S_LOADW: begin
                    if (n_q == ONE_N) begin
                        rd_en <= 1'b0;
                        state <= S_DRAIN;
                    end else begin
                        rd_addr <= rd_addr + 1'b1;
                        state   <= S_FEED;
                    end
                end
                S_FEED: begin
                    // Compare against N-1 rather than counting past it so a full buffer never wraps.
                    if ({1'b0, rd_addr} == n_q - ONE_N) begin
                        rd_en   <= 1'b0;
                        rd_addr <= '0;
                        state   <= S_DRAIN;
                    end else begin
                        rd_addr <= rd_addr + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (finish) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Datapath: feed counter, column skew, valid window, result realignment and write-back.
    always_ff @(posedge clk) begin
        if (reset) begin
            run     <= 1'b0;
            f       <= '0;
            valid   <= 1'b0;
            skew_q  <= 8'h00;
            hold_q  <= 8'h00;
            wcnt    <= '0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= 16'h0000;
        end else begin
            skew_q <= feed_row ? rd_data[15:8] : 8'h00;

            if (state == S_LOADW) begin
                run  <= 1'b1;
                f    <= '0;
                wcnt <= '0;
            end else if (finish) begin
                run <= 1'b0;
                f   <= '0;
            end else if (run) begin
                f <= f + ONE_F;
            end

            // valid covers every cycle from the first feed through the last column-1 capture.
            if (state == S_LOADW) begin
                valid <= 1'b1;
            end else if (last_cap) begin
                valid <= 1'b0;
            end

            if (cap0) begin
                hold_q <= acc_out1;
            end

            if (cap1) begin
                wr_en   <= 1'b1;
                wr_addr <= wcnt;
                wr_data <= {acc_out2, hold_q};
                wcnt    <= wcnt + 1'b1;
            end else begin
                wr_en <= 1'b0;
            end
        end
    end

`ifdef MMU_SEQ_PERF_EN
    // Busy-cycle counter: cleared by an accepted start, saturating, held after done.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_cycles <= 16'h0000;
        end else if (accept) begin
            perf_cycles <= 16'h0000;
        end else if (busy && (perf_cycles != 16'hFFFF)) begin
            perf_cycles <= perf_cycles + 16'h0001;
        end
    end
`endif

endmodule

// File: tb/tb_mmu_sequencer.sv
// Directed bench for mmu_sequencer with a behavioural 2x2 array and input buffer.
// Checks reset state, latency, result values, boundary sizes, ignored start and mid-job reset.
// Optional: build with MMU_SEQ_PERF_EN to also check perf_cycles.
module tb_mmu_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [4:0]  num_rows;
    logic [31:0] w_data;
    logic        busy, done, rd_en, load_weight, valid, wr_en;
    logic [3:0]  rd_addr, wr_addr;
    logic [15:0] rd_data, wr_data;
    logic [7:0]  a_in1, a_in2, weight1, weight2, weight3, weight4;
    logic [7:0]  acc_out1, acc_out2;
`ifdef MMU_SEQ_PERF_EN
    logic [15:0] perf_cycles;
`endif

    always #5 clk = ~clk;

    mmu_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .num_rows(num_rows), .w_data(w_data),
        .busy(busy), .done(done), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .load_weight(load_weight), .valid(valid), .a_in1(a_in1), .a_in2(a_in2),
        .weight1(weight1), .weight2(weight2), .weight3(weight3), .weight4(weight4),
        .acc_out1(acc_out1), .acc_out2(acc_out2),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
`ifdef MMU_SEQ_PERF_EN
        , .perf_cycles(perf_cycles)
`endif
    );

    // Input buffer: registered read, data one cycle after rd_en.
    logic [15:0] mem [0:15];
    always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

    // Behavioural array: col0 = a1*w1 + a2*w2 (2 cycles), col1 = a1*w3 + a2*w4 (3 cycles).
    logic [7:0] mw1, mw2, mw3, mw4, p1, s1, a1d, q, a2d, s2;
    always @(posedge clk) begin
        if (load_weight) begin
            mw1 <= weight1; mw2 <= weight2; mw3 <= weight3; mw4 <= weight4;
        end
        p1  <= a_in1 * mw1;
        s1  <= p1 + a_in2 * mw2;
        a1d <= a_in1;
        q   <= a1d * mw3;
        a2d <= a_in2;
        s2  <= q + a2d * mw4;
    end
    assign acc_out1 = s1;
    assign acc_out2 = s2;

    // Monitor on the falling edge, cycle numbers relative to the accepting cycle.
    int cyc = 0;
    int c0 = 0;
    int done_cnt, done_cyc, wr_cnt, rd_cnt, rd_bad, lw_cnt, valid_cnt, busy_at1;
    logic [3:0]  wr_a [0:31];
    logic [15:0] wr_d [0:31];
    int          wr_c [0:31];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (done) begin done_cnt <= done_cnt + 1; done_cyc <= cyc - c0; end
        if (wr_en && wr_cnt < 32) begin
            wr_a[wr_cnt] <= wr_addr; wr_d[wr_cnt] <= wr_data; wr_c[wr_cnt] <= cyc - c0;
            wr_cnt <= wr_cnt + 1;
        end
        if (rd_en) begin
            if (32'(rd_addr) != rd_cnt) rd_bad <= rd_bad + 1;
            rd_cnt <= rd_cnt + 1;
        end
        if (load_weight) lw_cnt <= lw_cnt + 1;
        if (valid) valid_cnt <= valid_cnt + 1;
        if (cyc - c0 == 1) busy_at1 <= 32'(busy);
    end

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_logs();
        done_cnt = 0; done_cyc = -1; wr_cnt = 0; rd_cnt = 0; rd_bad = 0;
        lw_cnt = 0; valid_cnt = 0; busy_at1 = 0;
    endtask

    task automatic start_job(input logic [4:0] n, input logic [31:0] w);
        clear_logs();
        num_rows = n; w_data = w; start = 1'b1; c0 = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        for (int i = 0; i < limit && done_cnt == 0; i++) tick();
        check("done_seen", done_cnt, 1);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_ctl"}, {busy, done, rd_en, wr_en, load_weight, valid}, 0);
        check({tag, "_a"}, {a_in1, a_in2}, 0);
        check({tag, "_w"}, {weight4, weight3, weight2, weight1}, 0);
        check({tag, "_addr"}, {rd_addr, wr_addr}, 0);
        check({tag, "_wdat"}, wr_data, 0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; num_rows = '0; w_data = '0;
        for (int i = 0; i < 16; i++) mem[i] = 16'h0000;
        clear_logs();
        tick(); tick(); tick();
        check_idle_outputs("reset");
        reset = 1'b0;
        tick();

        // Basic N=2 job.
        mem[0] = 16'h0201; mem[1] = 16'h0403;
        start_job(5'd2, 32'h04030201);
        wait_done(40);
        check("n2_done_cyc", done_cyc, 8);
        check("n2_wr_cnt", wr_cnt, 2);
        check("n2_wr0", {wr_a[0], wr_d[0]}, {4'd0, 16'h0B05});
        check("n2_wr1", {wr_a[1], wr_d[1]}, {4'd1, 16'h190B});
        check("n2_wr_consec", wr_c[1] - wr_c[0], 1);
        check("n2_rd", {rd_cnt, rd_bad}, {32'd2, 32'd0});
        check("n2_lw", lw_cnt, 1);
        check("n2_valid_cyc", valid_cnt, 5);
        check("n2_busy1", busy_at1, 1);
        check("n2_weights", {weight4, weight3, weight2, weight1}, 32'h04030201);
`ifdef MMU_SEQ_PERF_EN
        check("perf_n2", perf_cycles, 7);
        tick(); tick(); tick();
        check("perf_hold", perf_cycles, 7);
`endif
        tick();
        check("n2_idle_busy", {busy, done}, 0);

        // Empty job.
        start_job(5'd0, 32'hAABBCCDD);
        wait_done(10);
        for (int i = 0; i < 5; i++) tick();
        check("n0_done_cyc", done_cyc, 1);
        check("n0_done_cnt", done_cnt, 1);
        check("n0_activity", {rd_cnt, wr_cnt, lw_cnt}, 0);

        // Full buffer, N=16.
        for (int k = 0; k < 16; k++) mem[k] = {8'(k), 8'(k)};
        start_job(5'd16, 32'h01010101);
        wait_done(60);
        check("n16_done_cyc", done_cyc, 22);
        check("n16_wr_cnt", wr_cnt, 16);
        check("n16_rd", {rd_cnt, rd_bad}, {32'd16, 32'd0});
        for (int k = 0; k < 16; k++) begin
            logic [7:0] e;
            e = 8'(2 * k);
            check($sformatf("n16_wr%0d", k), {wr_a[k], wr_d[k]}, {4'(k), e, e});
        end
        tick();

        // Overflow wraps modulo 256.
        mem[0] = 16'h1010;
        start_job(5'd1, 32'h10101010);
        wait_done(30);
        check("ovf_done_cyc", done_cyc, 7);
        check("ovf_wr", {wr_cnt, 12'h000, wr_a[0], wr_d[0]}, {32'd1, 32'h0000_0000});
        tick();

        // Start pulsed during FEED, then reset in DRAIN.
        mem[0] = 16'h0201; mem[1] = 16'h0403; mem[2] = 16'h0605; mem[3] = 16'h0807;
        start_job(5'd4, 32'h04030201);
        tick();
        num_rows = 5'd0; w_data = 32'hFFFFFFFF; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        check("abort_busy_pre", busy, 1);
        check("abort_weights_kept", {weight4, weight3, weight2, weight1}, 32'h04030201);
        check("abort_lw_once", lw_cnt, 1);
        reset = 1'b1;
        tick();
        check_idle_outputs("abort");
        reset = 1'b0;
        clear_logs();
        for (int i = 0; i < 15; i++) tick();
        check("abort_no_done_wr", {done_cnt, wr_cnt}, 0);

        // Fresh N=1 job after the abort.
        mem[0] = 16'h0705;
        start_job(5'd1, 32'h04030201);
        wait_done(30);
        check("post_done_cyc", done_cyc, 7);
        check("post_wr", {wr_cnt, 12'h000, wr_a[0], wr_d[0]}, {32'd1, 32'h0000_2B13});
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
